// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 receive port.
//   * rx_state_e        : receiver FSM states
//   * STAT_OVF/PERR/IE  : bit positions in the status/control register
//   * DEF_BASE/DEPTH/TIMEOUT : default parameter values for ps2_port
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam int STAT_OVF  = 7;
    localparam int STAT_PERR = 6;
    localparam int STAT_IE   = 5;

    localparam logic [7:0] DEF_BASE    = 8'h60;
    localparam int         DEF_DEPTH   = 8;
    localparam int         DEF_TIMEOUT = 25000;  // 1 ms at 25 MHz

endpackage

// File: rtl/ps2_if.sv
// ps2_if -- CPU port bus between the host and ps2_port.
//   pin_pa   : port address          (host -> port)
//   pin_po   : port write data       (host -> port)
//   pin_pw   : port write strobe     (host -> port)
//   pin_pi   : port read data        (port -> host), combinational from pin_pa
//   pin_intr : level interrupt       (port -> host)
// Modports: master = host side, slave = ps2_port side.
interface ps2_if;

    logic [7:0] pin_pa;
    logic [7:0] pin_po;
    logic       pin_pw;
    logic [7:0] pin_pi;
    logic       pin_intr;

    modport master (
        output pin_pa,
        output pin_po,
        output pin_pw,
        input  pin_pi,
        input  pin_intr
    );

    modport slave (
        input  pin_pa,
        input  pin_po,
        input  pin_pw,
        output pin_pi,
        output pin_intr
    );

endinterface

// File: rtl/ps2_rx.sv
// ps2_rx -- PS/2 frame receiver: line synchronisers, falling-edge detect,
// IDLE/DATA/PARITY/STOP FSM and inter-edge watchdog.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   ps2_clk   : raw PS/2 clock line (asynchronous)
//   ps2_dat   : raw PS/2 data line (asynchronous)
//   rx_byte   : last received byte, valid while rx_valid is high
//   rx_valid  : one-cycle strobe, one clk after a good stop-bit edge
//   rx_perr   : one-cycle strobe for a frame with bad parity or stop bit
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_perr
);

    localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    rx_state_e       state_q,    state_d;
    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      dat_sync_q, dat_sync_d;
    logic            clk_prev_q, clk_prev_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [7:0]      shift_q,    shift_d;
    logic            parity_q,   parity_d;
    logic [WD_W-1:0] wd_q,       wd_d;
    logic            valid_q,    valid_d;
    logic            perr_q,     perr_d;

    logic fall;
    logic dat;

    // Third flop on the synchronised clock gives a one-cycle falling-edge pulse.
    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign dat  = dat_sync_q[1];

    always_comb begin
        // NOTE: every _d starts from a default so no branch can infer a latch.
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        clk_prev_d = clk_sync_q[1];
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        wd_d       = '0;
        valid_d    = 1'b0;
        perr_d     = 1'b0;

        // Watchdog only runs inside a frame; an edge restarts it.
        if (state_q != ST_IDLE) begin
            if (fall) begin
                wd_d = '0;
            end else if (wd_q == WD_MAX) begin
                state_d = ST_IDLE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};  // LSB arrives first
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // Odd parity over data+parity and a high stop bit.
                    if ((^{shift_q, parity_q}) && dat) begin
                        valid_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clk_sync_q <= 2'b11;   // idle-high line, so no false edge on release
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wd_q       <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            wd_q       <= wd_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
        end
    end

    assign rx_byte  = shift_q;
    assign rx_valid = valid_q;
    assign rx_perr  = perr_q;

endmodule

// File: rtl/ps2_port.sv
// ps2_port -- PS/2 keyboard port: receiver, byte FIFO and CPU port decode.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   ps2_clk, ps2_dat : raw PS/2 lines
//   bus (ps2_if.slave): CPU port; BASE = data (read head / write pops),
//                       BASE+1 = status/control {OVF, PERR, IE, 0, count[3:0]}
// Parameters: BASE, DEPTH (power of two, 2..16), TIMEOUT (clk per PS/2 edge).
// Build option: define PS2_INTR_EN to implement IE and a registered
// pin_intr = IE & (count != 0); otherwise pin_intr is 0 and IE reads 0.
module ps2_port
    import ps2_pkg::*;
#(
    parameter logic [7:0] BASE    = DEF_BASE,
    parameter int         DEPTH   = DEF_DEPTH,
    parameter int         TIMEOUT = DEF_TIMEOUT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ps2_clk,
    input  logic  ps2_dat,
    ps2_if.slave  bus
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [7:0]    STAT_ADDR = BASE + 8'd1;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_perr;

    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_perr  (rx_perr)
    );

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          perr_q,   perr_d;
    logic          pw_prev_q, pw_prev_d;

    logic       pw_rise, pop, push, full, wr_stat, ie;
    logic [3:0] cnt4;
    logic       unused_po;

    // Writes act once per strobe, however long pin_pw stays high.
    assign pw_rise = bus.pin_pw & ~pw_prev_q;
    assign wr_stat = pw_rise && (bus.pin_pa == STAT_ADDR);
    assign full    = (count_q == FULL);
    assign pop     = pw_rise && (bus.pin_pa == BASE) && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign push    = rx_valid && (!full || pop);
    assign cnt4    = 4'(count_q);

    always_comb begin
        pw_prev_d = bus.pin_pw;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        perr_d    = perr_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Clear first, set second: a same-cycle set wins.
        if (wr_stat && bus.pin_po[STAT_OVF])  ovf_d  = 1'b0;
        if (wr_stat && bus.pin_po[STAT_PERR]) perr_d = 1'b0;
        if (rx_valid && !push) ovf_d  = 1'b1;
        if (rx_perr)           perr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            pw_prev_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
            pw_prev_q <= pw_prev_d;
        end
    end

    // NOTE: FIFO storage is not reset; count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

`ifdef PS2_INTR_EN
    logic ie_q,   ie_d;
    logic intr_q, intr_d;

    always_comb begin
        ie_d = ie_q;
        if (wr_stat) ie_d = bus.pin_po[STAT_IE];
        // Registered from the committed count: rises one clk after a push.
        intr_d = ie_q && (count_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q   <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            intr_q <= intr_d;
        end
    end

    assign ie           = ie_q;
    assign bus.pin_intr = intr_q;
    assign unused_po    = ^bus.pin_po[4:0];
`else
    assign ie           = 1'b0;
    assign bus.pin_intr = 1'b0;
    assign unused_po    = ^bus.pin_po[5:0];
`endif

    // Unmatched addresses return 0 so several ports can be ORed together.
    always_comb begin
        bus.pin_pi = 8'h00;
        if (bus.pin_pa == BASE) begin
            if (count_q != '0) bus.pin_pi = mem_q[rd_ptr_q];
        end else if (bus.pin_pa == STAT_ADDR) begin
            bus.pin_pi[STAT_OVF]  = ovf_q;
            bus.pin_pi[STAT_PERR] = perr_q;
            bus.pin_pi[STAT_IE]   = ie;
            bus.pin_pi[3:0]       = cnt4;
        end
    end

endmodule

// File: doc/ps2_port.md
PS2_PORT -- requirements
Module: ps2_port

Interface
REQ-001 Parameter BASE, 8'h60, port address of the data port; status/control port is at BASE+1.
REQ-002 Parameter DEPTH, 8, FIFO depth in bytes; power of two, 2..16.
REQ-003 Parameter TIMEOUT, 25000, clk cycles allowed between PS/2 falling edges inside a frame (1 ms at 25 MHz).
REQ-004 clk  input  1  system clock (clk25 domain); the block has one clock.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 ps2_dat  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 pin_pa  input  8  CPU port address.
REQ-009 pin_po  input  8  CPU port write data.
REQ-010 pin_pw  input  1  CPU port write strobe; may stay high for more than one cycle.
REQ-011 pin_pi  output  8  CPU port read data; combinational from pin_pa.
REQ-012 pin_intr  output  1  interrupt request, level-sensitive.

Function
REQ-013 ps2_clk and ps2_dat SHALL each pass through two flops. A falling edge SHALL be detected with a third flop on the synchronised clock.
REQ-014 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP. All transitions SHALL occur only on a detected falling edge, except the watchdog transition.
REQ-015 IDLE: on an edge with dat=0, go to DATA with bit counter 0. An edge with dat=1 SHALL be ignored.
REQ-016 DATA: shift dat in LSB first. After the 8th bit, go to PARITY.
REQ-017 PARITY: sample the parity bit and go to STOP. The frame is good only if data plus parity have odd parity.
REQ-018 STOP: sample the stop bit and go to IDLE.
  - Good parity and stop=1: push the byte exactly one clk after the stop-bit edge is detected.
  - Otherwise: discard the byte and set sticky PERR.
REQ-019 Watchdog: in any state other than IDLE, a counter SHALL reset on each edge. When it reaches TIMEOUT-1, the FSM SHALL return to IDLE with no push and no flag.
REQ-020 FIFO occupancy range SHALL be 0..DEPTH.
  - Push when full: drop the byte and set sticky OVF.
  - Pop when empty: no effect.
  - Simultaneous push and pop: both take effect; if full, the push is accepted.
REQ-021 Pop SHALL occur on the first cycle of pin_pw with pin_pa==BASE. A multi-cycle strobe SHALL pop exactly once (rising-edge qualified).
REQ-022 Write to BASE+1 (rising-edge qualified):
  - po[7]=1 clears OVF.
  - po[6]=1 clears PERR.
  - po[5] loads IE.
  - Other bits are ignored.
  - A flag set and cleared in the same cycle SHALL end up set.
REQ-023 pin_pi values:
  - pa==BASE: FIFO head, or 8'h00 when empty.
  - pa==BASE+1: {OVF, PERR, IE, 1'b0, count[3:0]}.
  - Any other address: 8'h00, so the top level can OR ports together.
REQ-024 Reading SHALL have no side effects.

Reset
REQ-025 While rst is high:
  - FSM goes to IDLE.
  - Bit counter, watchdog, FIFO pointers and count are cleared.
  - OVF, PERR and IE are cleared.
  - Write-edge detector is cleared.
  - Synchronisers are set to 1 (idle-high line).
REQ-026 After rst, pin_pi SHALL equal 8'h00 at every address and pin_intr SHALL be 0.
REQ-027 Reset during a frame SHALL discard the partial frame. Remaining bits of that frame SHALL produce at most a PERR or a watchdog timeout, never a push.

Configuration
REQ-028 Macro PS2_INTR_EN.
  - Defined: pin_intr = IE AND (count != 0), registered, so it rises one clk after the push.
  - Not defined: pin_intr is tied 0, the IE bit is not implemented and reads 0, and po[5] is ignored.

Structure
REQ-029 Package ps2_pkg SHALL hold:
  - the FSM state enum;
  - status bit positions (OVF=7, PERR=6, IE=5);
  - default BASE, DEPTH and TIMEOUT constants.
REQ-030 Sub-module ps2_rx SHALL contain the synchroniser, FSM and watchdog. It outputs a byte plus a one-cycle valid strobe and a one-cycle perr strobe. FIFO and port decode stay in ps2_port.

Verification
REQ-031 Good frame: send start, 0x1C, parity 0, stop 1. Then read 0x60 -> 8'h1C and read 0x61 -> 8'h01. Write 0x60 -> status reads 8'h00.
REQ-032 Bad parity: send 0x1C with parity 1. Read 0x61 -> 8'h40 with no push. Write 8'h40 to 0x61 -> reads 8'h00.
REQ-033 Overflow: with DEPTH=8, push 9 frames 0x01..0x09. Read 0x61 -> 8'h88 and head 8'h01. Pop 8 times, reading 0x01..0x08 in order; 0x09 is lost.
REQ-034 Timeout: send start plus 3 data bits, stall for 25000 clk, then send a full frame 0xF0 with parity 1. FIFO SHALL hold only 0xF0, and PERR SHALL be 0.
REQ-035 Interrupt (PS2_INTR_EN): write 8'h20 to 0x61, then push 0x5A -> pin_intr=1 one clk after the push. A 3-cycle pin_pw write to 0x60 -> one pop, and pin_intr=0 on the next clk.
REQ-036 Reset mid-frame: assert rst after 4 data bits, then release it. Status reads 8'h00, and the next complete good frame 0x29 is the only FIFO entry.
